// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core with one shared memory port.
// FSM controller and datapath; trap state is sticky until reset.
module multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halt
);

  localparam int AW = (NREGS == 16) ? 4 : 5;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, JAL, ALUWB, BEQ, TRAP
  } state_t;

  state_t      state;
  state_t      dec_next;
  logic [31:0] ir, oldpc, a, b, aluout, mdr;
  logic [31:0] regs [NREGS];

  logic [6:0]  opc, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic [31:0] rv1, rv2, madr, btgt, jtgt;
  logic [31:0] opb, alu_y;
  logic        alu_ok, bad_reg, beq_trap;
  logic        use_rs1, use_rs2, use_rd;

  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7],
                  ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12],
                  ir[20], ir[30:21], 1'b0};

  assign rv1 = (rs1 == 5'd0) ? 32'd0 : regs[rs1[AW-1:0]];
  assign rv2 = (rs2 == 5'd0) ? 32'd0 : regs[rs2[AW-1:0]];

  assign madr = a + (opc[5] ? imm_s : imm_i);
  assign btgt = oldpc + imm_b;
  assign jtgt = oldpc + imm_j;

  assign beq_trap = (a == b) && (btgt[1:0] != 2'b00);
  assign halt     = (state == TRAP);

  // Opcode decode plus RV32E register-index legality
  always_comb begin
    dec_next = TRAP;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    unique case (opc)
      OP_LD: begin
        dec_next = MEMADR;
        use_rs1  = 1'b1;
        use_rd   = 1'b1;
      end
      OP_ST: begin
        dec_next = MEMADR;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OP_R: begin
        dec_next = EXECR;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        use_rd   = 1'b1;
      end
      OP_I: begin
        dec_next = EXECI;
        use_rs1  = 1'b1;
        use_rd   = 1'b1;
      end
      OP_BR: begin
        dec_next = (f3 == 3'b000) ? BEQ : TRAP;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OP_JAL: begin
        dec_next = JAL;
        use_rd   = 1'b1;
      end
      default: dec_next = TRAP;
    endcase
    bad_reg = (NREGS == 16) &&
              ((use_rs1 && rs1[4]) ||
               (use_rs2 && rs2[4]) ||
               (use_rd  && rd[4]));
    if (bad_reg) dec_next = TRAP;
  end

  // ALU for register and immediate forms, flags illegal funct codes
  always_comb begin
    opb    = (state == EXECR) ? b : imm_i;
    alu_y  = 32'd0;
    alu_ok = 1'b1;
    unique case (f3)
      3'b000: begin
        if (state == EXECR && f7[5]) alu_y = a - opb;
        else                         alu_y = a + opb;
      end
      3'b010:  alu_y = {31'd0, $signed(a) < $signed(opb)};
      3'b100:  alu_y = a ^ opb;
      3'b110:  alu_y = a | opb;
      3'b111:  alu_y = a & opb;
      default: alu_ok = 1'b0;
    endcase
    if (state == EXECR &&
        !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'b000)))
      alu_ok = 1'b0;
  end

  // Memory port and retire strobe, all gated off during reset
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {pc[31:2], 2'b00};
    mem_wdata = b;
    retire    = 1'b0;
    if (reset) begin
      unique case (state)
        FETCH: mem_req = 1'b1;
        MEMREAD: begin
          mem_req  = 1'b1;
          mem_addr = {aluout[31:2], 2'b00};
        end
        MEMWRITE: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          mem_addr = {aluout[31:2], 2'b00};
          retire   = mem_ready;
        end
        MEMWB, ALUWB: retire = 1'b1;
        BEQ:          retire = !beq_trap;
        default:      retire = 1'b0;
      endcase
    end
  end

  // Controller state, architectural state and datapath latches
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      ir     <= 32'd0;
      oldpc  <= 32'd0;
      a      <= 32'd0;
      b      <= 32'd0;
      aluout <= 32'd0;
      mdr    <= 32'd0;
      for (int i = 0; i < NREGS; i++) regs[i] <= 32'd0;
    end else begin
      unique case (state)
        FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata;
            oldpc <= pc;
            pc    <= pc + 32'd4;
            state <= DECODE;
          end
        end
        DECODE: begin
          a     <= rv1;
          b     <= rv2;
          state <= dec_next;
        end
        MEMADR: begin
          aluout <= madr;
          if (madr[1:0] != 2'b00) state <= TRAP;
          else if (opc[5])        state <= MEMWRITE;
          else                    state <= MEMREAD;
        end
        MEMREAD: begin
          if (mem_ready) begin
            mdr   <= mem_rdata;
            state <= MEMWB;
          end
        end
        MEMWB: begin
          if (rd != 5'd0) regs[rd[AW-1:0]] <= mdr;
          state <= FETCH;
        end
        MEMWRITE: begin
          if (mem_ready) state <= FETCH;
        end
        EXECR, EXECI: begin
          if (alu_ok) begin
            aluout <= alu_y;
            state  <= ALUWB;
          end else begin
            state <= TRAP;
          end
        end
        JAL: begin
          if (jtgt[1:0] != 2'b00) begin
            state <= TRAP;
          end else begin
            pc     <= jtgt;
            aluout <= oldpc + 32'd4;
            state  <= ALUWB;
          end
        end
        ALUWB: begin
          if (rd != 5'd0) regs[rd[AW-1:0]] <= aluout;
          state <= FETCH;
        end
        BEQ: begin
          if (beq_trap) begin
            state <= TRAP;
          end else begin
            if (a == b) pc <= btgt;
            state <= FETCH;
          end
        end
        TRAP:    state <= TRAP;
        default: state <= TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: memory model with
// programmable wait states, logs of writes, reads and retires.
module tb_multicycle_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we, mem_ready, retire, halt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  int          wait_n = 0;
  int          cnt = 0;
  int          cyc = 0;

  logic [31:0] wa_q[$], wd_q[$], ra_q[$];
  int          rt_q[$];
  logic [31:0] ea_q[$], ed_q[$];

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPL = 7'b0000011;

  always #5 clk = ~clk;

  multicycle_core #(.RESET_PC(32'h100), .NREGS(16)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .pc(pc), .retire(retire), .halt(halt)
  );

  assign mem_ready = mem_req && (cnt >= wait_n);
  assign mem_rdata = mem[mem_addr[9:2]];

  // memory model: wait counter, write commit, cycle count
  always @(posedge clk) begin
    if (!reset) begin
      cyc <= 0;
      cnt <= 0;
    end else begin
      cyc <= cyc + 1;
      if (mem_req && mem_ready) begin
        cnt <= 0;
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      end else if (mem_req) cnt <= cnt + 1;
      else cnt <= 0;
    end
  end

  // monitor: completed transactions and retire cycles
  always @(negedge clk) begin
    if (reset) begin
      if (retire) rt_q.push_back(cyc);
      if (mem_req && mem_ready) begin
        if (mem_we) begin
          wa_q.push_back(mem_addr);
          wd_q.push_back(mem_wdata);
        end else ra_q.push_back(mem_addr);
      end
    end
  end

  function automatic logic [31:0] r_op(input logic [6:0] f7,
      input int rs2, input int rs1, input logic [2:0] f3,
      input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] i_op(input int imm,
      input int rs1, input logic [2:0] f3, input int rd,
      input logic [6:0] op);
    return {12'(imm), 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] s_op(input int imm,
      input int rs2, input int rs1);
    logic [11:0] m;
    m = 12'(imm);
    return {m[11:5], 5'(rs2), 5'(rs1), 3'b010, m[4:0],
            7'b0100011};
  endfunction

  function automatic logic [31:0] b_op(input int imm,
      input int rs2, input int rs1, input logic [2:0] f3);
    logic [12:0] m;
    m = 13'(imm);
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), f3, m[4:1],
            m[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] j_op(input int imm,
      input int rd);
    logic [20:0] m;
    m = 21'(imm);
    return {m[20], m[10:1], m[11], m[19:12], 5'(rd),
            7'b1101111};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[9:2]] = w;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    wa_q.delete(); wd_q.delete(); ra_q.delete(); rt_q.delete();
    ea_q.delete(); ed_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic run_halt(input int budget, output bit to);
    int n;
    n = 0;
    while (!halt && n < budget) begin
      @(negedge clk);
      n++;
    end
    to = !halt;
  endtask

  task automatic pop_wr(output logic [31:0] a,
      output logic [31:0] d, output bit got);
    got = (wa_q.size() > 0);
    a = 32'hx;
    d = 32'hx;
    if (got) begin
      a = wa_q.pop_front();
      d = wd_q.pop_front();
    end
  endtask

  task automatic test_reset();
    clear_mem();
    put(32'h100, i_op(1, 0, 3'b000, 1, OPI));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0 || retire !== 1'b0) begin
      errors++;
      $display("FAIL rst_gate: req=%b ret=%b expected 0 0",
               mem_req, retire);
    end
    checks++;
    if (halt !== 1'b0) begin
      errors++;
      $display("FAIL rst_halt: got %b expected 0", halt);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      errors++;
      $display("FAIL rst_fetch: req=%b we=%b addr=%h expected 1 0 00000100",
               mem_req, mem_we, mem_addr);
    end
    checks++;
    if (pc !== 32'h100 || halt !== 1'b0) begin
      errors++;
      $display("FAIL rst_pc: pc=%h halt=%b expected 00000100 0",
               pc, halt);
    end
  endtask

  task automatic test_alu();
    logic [31:0] p[13];
    logic [31:0] ev[11];
    logic [31:0] a, d, xa, xd;
    bit to, got;
    wait_n = 0;
    clear_mem();
    p = '{i_op(5, 0, 3'b000, 1, OPI),
          i_op(-3, 0, 3'b000, 2, OPI),
          r_op(7'h00, 2, 1, 3'b000, 3),
          r_op(7'h20, 1, 2, 3'b000, 4),
          r_op(7'h00, 1, 2, 3'b010, 5),
          r_op(7'h00, 2, 1, 3'b100, 6),
          r_op(7'h00, 2, 1, 3'b110, 7),
          r_op(7'h00, 2, 1, 3'b111, 8),
          i_op(-2, 2, 3'b010, 9, OPI),
          i_op(-1, 1, 3'b100, 10, OPI),
          i_op(32'h30, 1, 3'b110, 11, OPI),
          i_op(32'h7F, 2, 3'b111, 12, OPI),
          r_op(7'h00, 2, 1, 3'b010, 13)};
    ev = '{32'h2, 32'hFFFF_FFF8, 32'h1, 32'hFFFF_FFF8,
           32'hFFFF_FFFD, 32'h5, 32'h1, 32'hFFFF_FFFA,
           32'h35, 32'h7D, 32'h0};
    for (int i = 0; i < 13; i++) put(32'h100 + 4 * i, p[i]);
    for (int k = 0; k < 11; k++)
      put(32'h134 + 4 * k, s_op(32'h300 + 4 * k, 3 + k, 0));
    put(32'h160, 32'h0000_007F);
    do_reset();
    for (int k = 0; k < 11; k++) begin
      ea_q.push_back(32'h300 + 4 * k);
      ed_q.push_back(ev[k]);
    end
    run_halt(500, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL alu_timeout: halt=%b expected 1", halt);
    end
    while (ea_q.size() > 0) begin
      xa = ea_q.pop_front();
      xd = ed_q.pop_front();
      pop_wr(a, d, got);
      checks++;
      if (!got || a !== xa || d !== xd) begin
        errors++;
        $display("FAIL alu_store: addr=%h data=%h expected %h %h",
                 a, d, xa, xd);
      end
    end
    checks++;
    if (rt_q.size() != 24) begin
      errors++;
      $display("FAIL alu_retires: got %0d expected 24", rt_q.size());
    end
    for (int i = 0; i < 13 && i < rt_q.size(); i++) begin
      checks++;
      if (rt_q[i] != 3 + 4 * i) begin
        errors++;
        $display("FAIL alu_retire_cyc%0d: got %0d expected %0d",
                 i, rt_q[i], 3 + 4 * i);
      end
    end
  endtask

  task automatic test_mem();
    logic [31:0] xr[6];
    logic [31:0] a, d, xa, xd, sa, sd;
    logic        swe;
    bit          pend, got;
    int          n;
    wait_n = 3;
    clear_mem();
    put(32'h100, i_op(5, 0, 3'b000, 1, OPI));
    put(32'h104, s_op(8, 1, 0));
    put(32'h108, i_op(8, 0, 3'b010, 6, OPL));
    put(32'h10C, s_op(32'h30C, 6, 0));
    put(32'h110, 32'h0000_007F);
    do_reset();
    ea_q.push_back(32'h8);   ed_q.push_back(32'h5);
    ea_q.push_back(32'h30C); ed_q.push_back(32'h5);
    xr = '{32'h100, 32'h104, 32'h108, 32'h8, 32'h10C, 32'h110};
    pend = 1'b0;
    sa = '0; sd = '0; swe = 1'b0;
    n = 0;
    while (!halt && n < 400) begin
      @(negedge clk);
      n++;
      if (pend) begin
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !==
            {1'b1, swe, sa, sd}) begin
          errors++;
          $display("FAIL mem_stable: req=%b we=%b addr=%h wd=%h expected 1 %b %h %h",
                   mem_req, mem_we, mem_addr, mem_wdata, swe, sa, sd);
        end
      end
      pend = mem_req && !mem_ready;
      sa = mem_addr; sd = mem_wdata; swe = mem_we;
    end
    checks++;
    if (!halt) begin
      errors++;
      $display("FAIL mem_timeout: halt=%b expected 1", halt);
    end
    while (ea_q.size() > 0) begin
      xa = ea_q.pop_front();
      xd = ed_q.pop_front();
      pop_wr(a, d, got);
      checks++;
      if (!got || a !== xa || d !== xd) begin
        errors++;
        $display("FAIL mem_store: addr=%h data=%h expected %h %h",
                 a, d, xa, xd);
      end
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= ra_q.size() || ra_q[i] !== xr[i]) begin
        errors++;
        $display("FAIL mem_read%0d: got %h expected %h", i,
                 (i < ra_q.size()) ? ra_q[i] : 32'hx, xr[i]);
      end
    end
    checks++;
    if (rt_q.size() < 3 || rt_q[1] - rt_q[0] != 10 ||
        rt_q[2] - rt_q[1] != 11) begin
      errors++;
      $display("FAIL mem_latency: retires=%0d expected sw 10 lw 11 cycles",
               rt_q.size());
    end
    wait_n = 0;
  endtask

  task automatic test_branch();
    logic [31:0] xr[10];
    logic [31:0] a, d, xa, xd;
    bit to, got;
    wait_n = 0;
    clear_mem();
    put(32'h100, i_op(1, 0, 3'b000, 1, OPI));
    put(32'h104, b_op(8, 1, 0, 3'b000));
    put(32'h108, j_op(-232, 0));
    put(32'h020, j_op(8, 7));
    put(32'h028, s_op(32'h310, 7, 0));
    put(32'h02C, j_op(8, 0));
    put(32'h030, j_op(12, 0));
    put(32'h034, b_op(-4, 1, 1, 3'b000));
    put(32'h03C, s_op(32'h314, 1, 0));
    put(32'h040, 32'h0000_007F);
    do_reset();
    ea_q.push_back(32'h310); ed_q.push_back(32'h24);
    ea_q.push_back(32'h314); ed_q.push_back(32'h1);
    xr = '{32'h100, 32'h104, 32'h108, 32'h20, 32'h28,
           32'h2C, 32'h34, 32'h30, 32'h3C, 32'h40};
    run_halt(400, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL br_timeout: halt=%b expected 1", halt);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= ra_q.size() || ra_q[i] !== xr[i]) begin
        errors++;
        $display("FAIL br_fetch%0d: got %h expected %h", i,
                 (i < ra_q.size()) ? ra_q[i] : 32'hx, xr[i]);
      end
    end
    while (ea_q.size() > 0) begin
      xa = ea_q.pop_front();
      xd = ed_q.pop_front();
      pop_wr(a, d, got);
      checks++;
      if (!got || a !== xa || d !== xd) begin
        errors++;
        $display("FAIL br_store: addr=%h data=%h expected %h %h",
                 a, d, xa, xd);
      end
    end
    checks++;
    if (rt_q.size() != 9 || rt_q[1] - rt_q[0] != 3 ||
        rt_q[3] - rt_q[2] != 4 || rt_q[6] - rt_q[5] != 3) begin
      errors++;
      $display("FAIL br_latency: retires=%0d expected 9 with beq 3 jal 4",
               rt_q.size());
    end
  endtask

  task automatic test_x0();
    logic [31:0] a, d;
    bit to, got;
    clear_mem();
    put(32'h100, i_op(9, 0, 3'b000, 0, OPI));
    put(32'h104, s_op(32'h318, 0, 0));
    put(32'h108, 32'h0000_007F);
    do_reset();
    ea_q.push_back(32'h318); ed_q.push_back(32'h0);
    run_halt(100, to);
    pop_wr(a, d, got);
    checks++;
    if (to || !got || a !== ea_q[0] || d !== ed_q[0]) begin
      errors++;
      $display("FAIL x0_store: addr=%h data=%h expected %h %h",
               a, d, ea_q[0], ed_q[0]);
    end
  endtask

  task automatic test_trap();
    logic [31:0] tw[6];
    bit to;
    tw = '{32'h0000_007F,
           i_op(3, 0, 3'b010, 1, OPL),
           r_op(7'h00, 1, 1, 3'b000, 17),
           b_op(6, 0, 0, 3'b000),
           r_op(7'h00, 1, 1, 3'b001, 2),
           b_op(8, 0, 0, 3'b001)};
    for (int t = 0; t < 6; t++) begin
      clear_mem();
      put(32'h100, tw[t]);
      put(32'h104, i_op(1, 0, 3'b000, 1, OPI));
      do_reset();
      run_halt(60, to);
      repeat (5) @(negedge clk);
      checks++;
      if (to || halt !== 1'b1 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL trap%0d_state: halt=%b req=%b expected 1 0",
                 t, halt, mem_req);
      end
      checks++;
      if (rt_q.size() != 0 || wa_q.size() != 0) begin
        errors++;
        $display("FAIL trap%0d_retire: retires=%0d writes=%0d expected 0 0",
                 t, rt_q.size(), wa_q.size());
      end
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (halt !== 1'b0 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL trap_clear: halt=%b req=%b expected 0 1",
               halt, mem_req);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    wait_n = 4;
    clear_mem();
    put(32'h100, i_op(1, 0, 3'b000, 1, OPI));
    put(32'h104, i_op(2, 0, 3'b000, 2, OPI));
    do_reset();
    n = 0;
    while (!(rt_q.size() == 1 && mem_req && !mem_ready &&
             mem_addr == 32'h104) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL mid_pending: addr=%h expected 00000104", mem_addr);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0 || pc !== 32'h100) begin
      errors++;
      $display("FAIL mid_abort: req=%b pc=%h expected 0 00000100",
               mem_req, pc);
    end
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL mid_restart: req=%b addr=%h expected 1 00000100",
               mem_req, mem_addr);
    end
    wait_n = 0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_x0();
    test_trap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
